// File: rtl/cnn_layer_accel_awe_macc_ctrl.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_awe_macc_ctrl
//
// Front-end controller for an external pipelined multiply-accumulate unit.
// Operand pairs are grouped into accumulation windows of cfg_kernel_len
// products. The first product of a window is steered into the MACC with
// macc_start_new_macc (P = M). Later products accumulate (P = P + M). The
// finished sum is captured from macc_P into a small result FIFO.
//
// MACC pipeline assumed, relative to the cycle k in which an operand is on
// macc_A/macc_B:
//   k+1 A/B input registers, k+2 M register, k+3 OPMODE/M2 registers,
//   k+4 P register holds the updated sum.
//
// Optional feature: define CNN_LAYER_ACCEL_MACC_RELU_EN to clamp negative
// sums to zero as they are written into the result FIFO.
// -----------------------------------------------------------------------------
module cnn_layer_accel_awe_macc_ctrl #(
  parameter int C_A_INPUT_WIDTH  = 30,
  parameter int C_B_INPUT_WIDTH  = 18,
  parameter int C_P_OUTPUT_WIDTH = 48,
  parameter int RES_FIFO_DEPTH   = 4
) (
  input  logic                        CLK,
  input  logic                        rst,
  input  logic [7:0]                  cfg_kernel_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [C_A_INPUT_WIDTH-1:0]  in_a,
  input  logic [C_B_INPUT_WIDTH-1:0]  in_b,
  output logic [C_A_INPUT_WIDTH-1:0]  macc_A,
  output logic [C_B_INPUT_WIDTH-1:0]  macc_B,
  output logic                        macc_CE,
  output logic                        macc_start_new_macc,
  output logic [8:0]                  macc_opmode,
  input  logic [C_P_OUTPUT_WIDTH-1:0] macc_P,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [C_P_OUTPUT_WIDTH-1:0] res_data,
  output logic                        busy
);

  // Pointer width for the result FIFO; one extra bit separates full from empty.
  localparam int AW = $clog2(RES_FIFO_DEPTH);

  // FIRST tag delay: operand on macc_A at t+1, OPMODE register loads at t+3.
  localparam int FIRST_DLY = 3;

  // LAST tag delay: operand on macc_A at t+1, final sum on macc_P at t+5.
  localparam int LAST_DLY = 5;

  // OPMODE value selecting P = M (start a new sum).
  localparam logic [8:0] OPMODE_NEW_SUM = 9'b000000101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e                      state_q, state_d;
  logic [7:0]                  len_q, len_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic [7:0]                  eff_len;

  logic                        ready_int;
  logic                        accept;
  logic                        tag_first;
  logic                        tag_last;

  logic [C_A_INPUT_WIDTH-1:0]  macc_a_q;
  logic [C_B_INPUT_WIDTH-1:0]  macc_b_q;
  logic [FIRST_DLY-1:0]        first_sr_q;
  logic [LAST_DLY-1:0]         last_sr_q;

  logic [3:0]                  tags_inflight;
  logic [15:0]                 reserved;
  logic                        room;

  logic [C_P_OUTPUT_WIDTH-1:0] fifo_mem_q [RES_FIFO_DEPTH];
  logic [AW:0]                 wr_ptr_q;
  logic [AW:0]                 rd_ptr_q;
  logic [AW:0]                 fifo_cnt;
  logic                        fifo_empty;
  logic                        push;
  logic                        pop;
  logic [C_P_OUTPUT_WIDTH-1:0] push_data;

  // ---------------------------------------------------------------------------
  // Slot reservation
  // ---------------------------------------------------------------------------

  // A zero length is treated as a single-product window.
  assign eff_len = (cfg_kernel_len == 8'd0) ? 8'd1 : cfg_kernel_len;

  // Count LAST tags still travelling towards the FIFO.
  always_comb begin
    tags_inflight = 4'd0;
    for (int i = 0; i < LAST_DLY; i++) begin
      tags_inflight = tags_inflight + 4'(last_sr_q[i]);
    end
  end

  assign fifo_cnt = wr_ptr_q - rd_ptr_q;
  assign reserved = 16'(fifo_cnt) + 16'(tags_inflight);
  assign room     = (reserved < 16'(RES_FIFO_DEPTH));

  // ---------------------------------------------------------------------------
  // Window FSM
  // ---------------------------------------------------------------------------

  // State register: window state, latched length and accept count.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, handshake and FIRST/LAST tagging.
  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    tag_first = 1'b0;
    tag_last  = 1'b0;

    // An open window already owns its FIFO slot; a new window needs a free one.
    ready_int = (state_q == S_ACC) || room;
    accept    = in_valid && ready_int && !rst;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tag_first = 1'b1;
          len_d     = eff_len;
          cnt_d     = 8'd1;
          if (eff_len == 8'd1) begin
            tag_last = 1'b1;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        // cfg_kernel_len is not looked at here; len_q holds the window length.
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == len_q) begin
            tag_last = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready = ready_int && !rst;

  // ---------------------------------------------------------------------------
  // Operand registers and tag delay lines
  // ---------------------------------------------------------------------------

  // Register the accepted operands; idle cycles feed zeros so P + M holds P.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      macc_a_q <= '0;
      macc_b_q <= '0;
    end else if (accept) begin
      macc_a_q <= in_a;
      macc_b_q <= in_b;
    end else begin
      macc_a_q <= '0;
      macc_b_q <= '0;
    end
  end

  // Delay FIRST to the OPMODE register stage and LAST to the P output stage.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      first_sr_q <= '0;
      last_sr_q  <= '0;
    end else begin
      first_sr_q <= {first_sr_q[FIRST_DLY-2:0], tag_first};
      last_sr_q  <= {last_sr_q[LAST_DLY-2:0], tag_last};
    end
  end

  assign macc_A              = macc_a_q;
  assign macc_B              = macc_b_q;
  assign macc_start_new_macc = first_sr_q[FIRST_DLY-1];
  assign macc_CE             = !rst;
  assign macc_opmode         = rst ? 9'd0 : OPMODE_NEW_SUM;

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  assign push       = last_sr_q[LAST_DLY-1];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign pop        = !fifo_empty && res_ready;

`ifdef CNN_LAYER_ACCEL_MACC_RELU_EN
  // Negative sums are clamped to zero on their way into the FIFO.
  assign push_data = macc_P[C_P_OUTPUT_WIDTH-1] ? '0 : macc_P;
`else
  assign push_data = macc_P;
`endif

  // FIFO pointers; push and pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // FIFO storage write.
  // NOTE: storage is not reset; the pointers alone decide which entries are
  // valid, and res_data is forced to zero while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  assign res_valid = !fifo_empty;
  assign res_data  = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign busy      = !rst && ((state_q == S_ACC) || (|last_sr_q) || !fifo_empty);

endmodule

// File: tb/tb_cnn_layer_accel_awe_macc_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for cnn_layer_accel_awe_macc_ctrl.
// A behavioural MACC model closes the loop on macc_P. The driver computes each
// window's expected sum from the window rules and queues it. A monitor pops
// results and start pulses as the DUT presents them.
// Honours CNN_LAYER_ACCEL_MACC_RELU_EN in the expected values.
// -----------------------------------------------------------------------------
module tb_cnn_layer_accel_awe_macc_ctrl;

  localparam int AW_W  = 30;
  localparam int BW_W  = 18;
  localparam int PW_W  = 48;
  localparam int DEPTH = 4;
  localparam int ACCEPT_LIMIT = 300;
  localparam int DRAIN_LIMIT  = 600;

  logic                   CLK;
  logic                   rst;
  logic [7:0]             cfg_kernel_len;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [AW_W-1:0] in_a;
  logic signed [BW_W-1:0] in_b;
  logic [AW_W-1:0]        macc_A;
  logic [BW_W-1:0]        macc_B;
  logic                   macc_CE;
  logic                   macc_start_new_macc;
  logic [8:0]             macc_opmode;
  logic [PW_W-1:0]        macc_P;
  logic                   res_valid;
  logic                   res_ready;
  logic [PW_W-1:0]        res_data;
  logic                   busy;

  cnn_layer_accel_awe_macc_ctrl #(
    .C_A_INPUT_WIDTH (AW_W),
    .C_B_INPUT_WIDTH (BW_W),
    .C_P_OUTPUT_WIDTH(PW_W),
    .RES_FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK                (CLK),
    .rst                (rst),
    .cfg_kernel_len     (cfg_kernel_len),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_a               (in_a),
    .in_b               (in_b),
    .macc_A             (macc_A),
    .macc_B             (macc_B),
    .macc_CE            (macc_CE),
    .macc_start_new_macc(macc_start_new_macc),
    .macc_opmode        (macc_opmode),
    .macc_P             (macc_P),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .busy               (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural MACC: A/B regs, M reg, M2 + OPMODE regs, P reg.
  logic signed [AW_W-1:0] a1;
  logic signed [BW_W-1:0] b1;
  logic [PW_W-1:0]        m1, m2, p_reg;
  logic                   op_new;

  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      a1 <= '0; b1 <= '0; m1 <= '0; m2 <= '0; op_new <= 1'b0; p_reg <= '0;
    end else if (macc_CE) begin
      a1     <= macc_A;
      b1     <= macc_B;
      m1     <= 48'(longint'(a1) * longint'(b1));
      m2     <= m1;
      op_new <= macc_start_new_macc;
      p_reg  <= op_new ? m2 : p_reg + m2;
    end
  end
  assign macc_P = p_reg;

  // Scoreboard
  typedef struct {
    logic [PW_W-1:0] data;
    int              acc_cyc;
    bit              exact;
  } exp_t;

  exp_t exp_q[$];
  int   start_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_res = 0;

  bit              in_win = 1'b0;
  int              win_len, win_n;
  logic [PW_W-1:0] win_sum;
  bit              exact_mode = 1'b0;
  bit              rr_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event did not match expectation (cycle %0d)", name, cyc);
  endtask

  function automatic logic [PW_W-1:0] relu(input logic [PW_W-1:0] v);
`ifdef CNN_LAYER_ACCEL_MACC_RELU_EN
    return v[PW_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Reference window model: called at the negedge in which an accept happens.
  task automatic model_accept(input logic signed [AW_W-1:0] a, input logic signed [BW_W-1:0] b);
    longint p;
    exp_t   e;
    if (!in_win) begin
      win_len = (cfg_kernel_len == 8'd0) ? 1 : int'(cfg_kernel_len);
      win_n   = 0;
      win_sum = '0;
      in_win  = 1'b1;
      start_q.push_back(cyc + 3);
    end
    p       = longint'(a) * longint'(b);
    win_sum = win_sum + p[PW_W-1:0];
    win_n++;
    if (win_n == win_len) begin
      e.data    = relu(win_sum);
      e.acc_cyc = cyc;
      e.exact   = exact_mode;
      exp_q.push_back(e);
      in_win = 1'b0;
    end
  endtask

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  // Offer one operand pair; called and returns at posedge+1.
  task automatic send(input int a, input int b, input int gap);
    int waitc;
    bit ok;
    waitc    = 0;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_a     = AW_W'(a);
    in_b     = BW_W'(b);
    while (!ok && waitc < ACCEPT_LIMIT) begin
      @(negedge CLK);
      if (in_ready) ok = 1'b1;
      else waitc++;
    end
    if (ok) model_accept(in_a, in_b);
    else fail_now("accept_timeout");
    sync();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (gap) sync();
  endtask

  task automatic drain();
    int k;
    k = 0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || start_q.size() != 0 || busy) && k < DRAIN_LIMIT) begin
      @(negedge CLK);
      k++;
    end
    if (k >= DRAIN_LIMIT) fail_now("drain_timeout");
    sync();
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready",  64'(in_ready),            64'd0);
    check("rst_macc_CE",   64'(macc_CE),             64'd0);
    check("rst_busy",      64'(busy),                64'd0);
    check("rst_res_valid", 64'(res_valid),           64'd0);
    check("rst_res_data",  64'(res_data),            64'd0);
    check("rst_start",     64'(macc_start_new_macc), 64'd0);
    check("rst_opmode",    64'(macc_opmode),         64'd0);
    check("rst_macc_A",    64'(macc_A),              64'd0);
    check("rst_macc_B",    64'(macc_B),              64'd0);
  endtask

  // Asserted at posedge+1; discards all expectations of the open model state.
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    start_q.delete();
    in_win = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check_reset_outputs();
    end
    sync();
    rst = 1'b0;
    @(negedge CLK);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    check("macc_CE_after_rst",  64'(macc_CE),  64'd1);
    check("opmode_after_rst",   64'(macc_opmode), 64'h5);
    sync();
  endtask

  // Monitor: compares start pulses and popped results against the queues.
  bit   head_seen = 1'b0;
  int   head_since = 0;
  exp_t mon_e;
  int   mon_t;

  initial begin
    forever begin
      @(negedge CLK);
      if (rst) begin
        head_seen = 1'b0;
      end else begin
        if (start_q.size() != 0 && start_q[0] < cyc) begin
          fail_now("start_missing");
          void'(start_q.pop_front());
        end
        if (macc_start_new_macc) begin
          if (start_q.size() == 0) begin
            fail_now("start_unexpected");
          end else begin
            mon_t = start_q.pop_front();
            check("start_cycle", 64'(cyc), 64'(mon_t));
          end
        end
        if (res_valid) begin
          if (!head_seen) begin
            head_seen  = 1'b1;
            head_since = cyc;
          end
          if (res_ready) begin
            if (exp_q.size() == 0) begin
              fail_now("res_unexpected");
            end else begin
              mon_e = exp_q.pop_front();
              check("res_data", 64'(res_data), 64'(mon_e.data));
              if (mon_e.exact)
                check("res_latency", 64'(head_since - mon_e.acc_cyc), 64'd6);
              else
                check("res_latency_min", 64'((head_since - mon_e.acc_cyc) >= 6), 64'd1);
            end
            n_res++;
            head_seen = 1'b0;
          end
        end
      end
    end
  end

  // Random back-pressure on the result port when enabled.
  initial begin
    forever begin
      sync();
      if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  function automatic int pick_a();
    case ($urandom_range(0, 4))
      0:       return -(1 << 29);
      1:       return (1 << 29) - 1;
      default: return int'($urandom());
    endcase
  endfunction

  function automatic int pick_b();
    case ($urandom_range(0, 4))
      0:       return -(1 << 17);
      1:       return (1 << 17) - 1;
      default: return int'($urandom());
    endcase
  endfunction

  // Stimulus
  int res_before;
  int guard;

  initial begin
    rst            = 1'b1;
    cfg_kernel_len = 8'd0;
    in_valid       = 1'b0;
    in_a           = '0;
    in_b           = '0;
    res_ready      = 1'b0;

    repeat (2) begin
      @(negedge CLK);
      check_reset_outputs();
    end
    sync();
    rst = 1'b0;
    @(negedge CLK);
    check("in_ready_first_cycle", 64'(in_ready), 64'd1);
    check("macc_CE_first_cycle",  64'(macc_CE),  64'd1);
    sync();

    // len=3 back-to-back, exact latency and single start pulse
    cfg_kernel_len = 8'd3;
    res_ready      = 1'b1;
    exact_mode     = 1'b1;
    send(2, 3, 0);
    send(4, 5, 0);
    send(-1, 6, 0);
    exact_mode = 1'b0;
    drain();

    // zero length behaves as one: 1,4,9,16
    cfg_kernel_len = 8'd0;
    for (int i = 1; i <= 4; i++) send(i, i, 0);
    drain();

    // back-pressure: four windows fill the FIFO reservation
    cfg_kernel_len = 8'd2;
    res_ready      = 1'b0;
    for (int w = 0; w < 4; w++) begin
      send(w + 1, 2, 0);
      send(w + 3, -3, 0);
      if (w == 2) begin
        @(negedge CLK);
        check("in_ready_3_reserved", 64'(in_ready), 64'd1);
        sync();
      end
    end
    repeat (8) @(negedge CLK);
    check("in_ready_4_reserved", 64'(in_ready),  64'd0);
    check("busy_fifo_full",      64'(busy),      64'd1);
    check("res_valid_fifo_full", 64'(res_valid), 64'd1);
    sync();
    res_ready = 1'b1;
    for (int w = 4; w < 6; w++) begin
      send(w + 1, 2, 0);
      send(w + 3, -3, 0);
    end
    drain();

    // len=4 with in_valid toggling: 4*49
    cfg_kernel_len = 8'd4;
    for (int i = 0; i < 4; i++) send(7, 7, 1);
    drain();

    // negative sum: -49, or 0 with the clamp enabled
    cfg_kernel_len = 8'd2;
    send(-5, 10, 0);
    send(1, 1, 0);
    drain();

    // reset with a result in the FIFO path and a window open
    res_ready      = 1'b0;
    cfg_kernel_len = 8'd1;
    send(5, 5, 0);
    cfg_kernel_len = 8'd4;
    send(9, 9, 0);
    send(9, 9, 0);
    do_reset();
    res_ready      = 1'b1;
    res_before     = n_res;
    cfg_kernel_len = 8'd2;
    send(3, 3, 0);
    send(1, 1, 0);
    drain();
    check("one_result_after_rst", 64'(n_res - res_before), 64'd1);

    // randomized windows, gaps, mid-window length changes and back-pressure
    rr_rand = 1'b1;
    for (int w = 0; w < 40; w++) begin
      cfg_kernel_len = 8'($urandom_range(0, 6));
      guard = 0;
      send(pick_a(), pick_b(), int'($urandom_range(0, 3) == 0));
      while (in_win && guard < 16) begin
        cfg_kernel_len = 8'($urandom_range(0, 7));
        send(pick_a(), pick_b(), int'($urandom_range(0, 3) == 0));
        guard++;
      end
    end
    rr_rand = 1'b0;
    sync();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
